// File: rtl/escalonador_pedidos.sv
// escalonador_pedidos
// Round-robin scheduler sharing one display stage between four requesters (A..D).
// A granted requester and its decoded destination are held on the one-hot output
// lines for SERVICE_CYCLES cycles. A one-cycle release follows, then one idle cycle
// before the next arbitration.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_req    - level requests, bit 0 = A .. bit 3 = D
//   i_dest   - 2-bit destination per requester, i_dest[2i+1:2i] for i_req[i]
//   o_gnt    - one-cycle one-hot pulse marking the accepted requester
//   o_outa..o_outd     - one-hot served requester
//   o_out00/01/10      - one-hot destination of the served requester
//   o_busy   - high while serving or releasing
//   o_err    - one-cycle pulse when the winner carries destination 11
module escalonador_pedidos #(
  parameter int unsigned SERVICE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic [7:0] i_dest,
  output logic [3:0] o_gnt,
  output logic       o_outa,
  output logic       o_outb,
  output logic       o_outc,
  output logic       o_outd,
  output logic       o_out00,
  output logic       o_out01,
  output logic       o_out10,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] LoadVal = 8'(SERVICE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StServe, StRelease} state_e;

  state_e     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt;
  logic [3:0] r_outs;
  logic [2:0] r_dst;
  logic       r_busy;
  logic       r_err;

  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic [1:0] w_win_dest;
  logic [2:0] w_dst_dec;

  // Winner is the first set request searching upward from the slot after r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_dest = i_dest[{w_win, 1'b0} +: 2];

  always_comb begin
    w_dst_dec = 3'b000;
    unique case (w_win_dest)
      2'b00:   w_dst_dec = 3'b001;
      2'b01:   w_dst_dec = 3'b010;
      2'b10:   w_dst_dec = 3'b100;
      default: w_dst_dec = 3'b000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_ptr   <= 2'd3;
      r_cnt   <= 8'd0;
      r_gnt   <= 4'b0000;
      r_outs  <= 4'b0000;
      r_dst   <= 3'b000;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_gnt  <= 4'b0000;
          r_err  <= 1'b0;
          r_outs <= 4'b0000;
          r_dst  <= 3'b000;
          r_busy <= 1'b0;
          if (w_found) begin
            r_gnt <= 4'b0001 << w_win;
            r_ptr <= w_win;
            if (w_win_dest == 2'b11) begin
              // Invalid destination: skip this winner, re-arbitrate next cycle.
              r_err <= 1'b1;
            end else begin
              r_outs  <= 4'b0001 << w_win;
              r_dst   <= w_dst_dec;
              r_cnt   <= LoadVal;
              r_busy  <= 1'b1;
              r_state <= StServe;
            end
          end
        end
        StServe: begin
          r_gnt <= 4'b0000;
          r_err <= 1'b0;
          if (r_cnt == 8'd0) begin
            r_outs  <= 4'b0000;
            r_dst   <= 3'b000;
            r_state <= StRelease;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StRelease: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_gnt   = r_gnt;
  assign o_outa  = r_outs[0];
  assign o_outb  = r_outs[1];
  assign o_outc  = r_outs[2];
  assign o_outd  = r_outs[3];
  assign o_out00 = r_dst[0];
  assign o_out01 = r_dst[1];
  assign o_out10 = r_dst[2];
  assign o_busy  = r_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_escalonador_pedidos.sv
// Self-checking bench for escalonador_pedidos: a timeline model (grant cycle and
// service window per winner) checked against the DUT every cycle, plus directed
// literal checks taken from the test plan.
module tb_escalonador_pedidos;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] dest = 8'h00;
  logic [3:0] o_gnt;
  logic       o_outa, o_outb, o_outc, o_outd;
  logic       o_out00, o_out01, o_out10;
  logic       o_busy, o_err;

  int n_checks = 0;
  int n_fail   = 0;

  escalonador_pedidos #(
    .SERVICE_CYCLES(S)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_dest (dest),
    .o_gnt  (o_gnt),
    .o_outa (o_outa),
    .o_outb (o_outb),
    .o_outc (o_outc),
    .o_outd (o_outd),
    .o_out00(o_out00),
    .o_out01(o_out01),
    .o_out10(o_out10),
    .o_busy (o_busy),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: cycle index after each edge; a valid grant at cycle n owns
  // outputs for cycles n..n+S-1, busy for n..n+S, and the next arbitration at n+S+2.
  int         cyc = 0;
  int         m_ptr = 3;
  int         m_free_at = 1;
  int         m_gnt_cyc = -1;
  int         m_gnt_w = 0;
  bit         m_err = 1'b0;
  int         m_srv_start = -1000;
  int         m_srv_w = 0;
  logic [1:0] m_srv_d = 2'b00;
  int         m_w;
  logic [1:0] m_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc         = 0;
      m_ptr       = 3;
      m_free_at   = 1;
      m_gnt_cyc   = -1;
      m_err       = 1'b0;
      m_srv_start = -1000;
    end else begin
      cyc++;
      if (cyc >= m_free_at && req != 4'b0000) begin
        m_w = -1;
        for (int i = 1; i <= 4; i++) begin
          if (m_w < 0 && req[(m_ptr + i) % 4]) m_w = (m_ptr + i) % 4;
        end
        m_d       = dest[2*m_w +: 2];
        m_gnt_cyc = cyc;
        m_gnt_w   = m_w;
        m_ptr     = m_w;
        if (m_d == 2'b11) begin
          m_err     = 1'b1;
          m_free_at = cyc + 1;
        end else begin
          m_err       = 1'b0;
          m_srv_start = cyc;
          m_srv_w     = m_w;
          m_srv_d     = m_d;
          m_free_at   = cyc + S + 2;
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  logic [12:0] act_v, exp_v;
  logic [3:0]  e_gnt, e_out;
  logic [2:0]  e_dst;
  logic        e_busy, e_err;
  bit          in_srv;

  always @(negedge clk) begin
    e_gnt  = (cyc == m_gnt_cyc) ? 4'(1 << m_gnt_w) : 4'b0000;
    e_err  = (cyc == m_gnt_cyc) && m_err;
    in_srv = (cyc >= m_srv_start) && (cyc < m_srv_start + S);
    e_out  = in_srv ? 4'(1 << m_srv_w) : 4'b0000;
    e_dst  = !in_srv ? 3'b000 : (m_srv_d == 2'b00) ? 3'b001 :
             (m_srv_d == 2'b01) ? 3'b010 : 3'b100;
    e_busy = (cyc >= m_srv_start) && (cyc <= m_srv_start + S);
    exp_v  = {e_gnt, e_out, e_dst, e_busy, e_err};
    act_v  = {o_gnt, o_outd, o_outc, o_outb, o_outa, o_out10, o_out01, o_out00,
              o_busy, o_err};
    chk("cycle", 32'(act_v), 32'(exp_v));
  end

  // Grant logger for the round-robin order and spacing check.
  int  g_cyc[$];
  logic [3:0] g_val[$];
  bit  log_en = 1'b0;
  always @(negedge clk) begin
    if (log_en && o_gnt != 4'b0000) begin
      g_cyc.push_back(cyc);
      g_val.push_back(o_gnt);
    end
  end

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cnt_out, cnt_busy, cnt_gnt, held;
  logic [12:0] all_out;

  initial begin
    // Reset values with all requests high.
    rst  = 1'b1;
    req  = 4'b1111;
    dest = 8'h00;
    idle_wait(3);
    all_out = {o_gnt, o_outa, o_outb, o_outc, o_outd, o_out00, o_out01, o_out10,
               o_busy, o_err};
    chk("reset_outputs", 32'(all_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant_gnt", 32'(o_gnt), 32'h1);
    chk("first_grant_outa", 32'(o_outa), 32'h1);
    req = 4'b0000;
    idle_wait(12);

    // Single request C to destination 01.
    req  = 4'b0100;
    dest = 8'b0001_0000;
    cnt_out = 0; cnt_busy = 0; cnt_gnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) req = 4'b0000;
      if (o_outc && o_out01) cnt_out++;
      if (o_busy) cnt_busy++;
      if (o_gnt == 4'b0100) cnt_gnt++;
    end
    chk("single_out_cycles", 32'(cnt_out), 32'd8);
    chk("single_busy_cycles", 32'(cnt_busy), 32'd9);
    chk("single_gnt_pulses", 32'(cnt_gnt), 32'd1);

    // Round-robin from reset with all requests held.
    pulse_reset();
    g_cyc.delete();
    g_val.delete();
    log_en = 1'b1;
    req  = 4'b1111;
    dest = 8'h00;
    idle_wait(45);
    log_en = 1'b0;
    req = 4'b0000;
    chk("rr_grant_count", 32'(g_val.size()), 32'd5);
    if (g_val.size() == 5) begin
      chk("rr_order_0", 32'(g_val[0]), 32'h1);
      chk("rr_order_1", 32'(g_val[1]), 32'h2);
      chk("rr_order_2", 32'(g_val[2]), 32'h4);
      chk("rr_order_3", 32'(g_val[3]), 32'h8);
      chk("rr_order_4", 32'(g_val[4]), 32'h1);
      for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd10);
    end
    idle_wait(12);

    // Invalid destination on A skips to B.
    pulse_reset();
    req  = 4'b0011;
    dest = 8'b0000_1011;
    @(negedge clk);
    chk("inv_gnt", 32'(o_gnt), 32'h1);
    chk("inv_err", 32'(o_err), 32'h1);
    chk("inv_no_out", 32'({o_outa, o_outb, o_outc, o_outd}), 32'h0);
    req = 4'b0010;
    @(negedge clk);
    chk("inv_next_gnt", 32'(o_gnt), 32'h2);
    chk("inv_next_outb_out10", 32'({o_outb, o_out10, o_err}), 32'b110);
    req = 4'b0000;
    idle_wait(12);

    // Mid-service changes on A are ignored.
    req  = 4'b0001;
    dest = 8'b0000_0010;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req  = 4'b0000;
        dest = 8'b0000_0001;
      end
      if (o_outa && o_out10 && !o_out01) held++;
    end
    chk("mid_change_held", 32'(held), 32'd8);
    idle_wait(4);

    // Reset in the third service cycle of B.
    req  = 4'b0010;
    dest = 8'h00;
    idle_wait(3);
    chk("pre_reset_outb", 32'(o_outb), 32'h1);
    #2;
    rst = 1'b1;
    req = 4'b1111;
    #1;
    all_out = {o_gnt, o_outa, o_outb, o_outc, o_outd, o_out00, o_out01, o_out10,
               o_busy, o_err};
    chk("async_reset_clear", 32'(all_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_gnt", 32'(o_gnt), 32'h1);
    chk("post_reset_outa", 32'(o_outa), 32'h1);
    req = 4'b0000;
    idle_wait(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
